// File: rtl/cgra_power_seq_pkg.sv
// Shared types for the CGRA external-domain power sequencer: state encoding,
// timer width and the state-to-pin decode used for the registered outputs.
package cgra_power_seq_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [3:0] {
      ST_ON      = 4'd0,
      ST_CLK_OFF = 4'd1,
      ST_ISO     = 4'd2,
      ST_SW_OFF  = 4'd3,
      ST_OFF     = 4'd4,
      ST_SW_ON   = 4'd5,
      ST_SETTLE  = 4'd6,
      ST_ISO_REL = 4'd7,
      ST_RST_REL = 4'd8,
      ST_ERR     = 4'd9
   } pwr_state_e;

   typedef struct packed {
      logic switch_on;
      logic iso;
      logic rst_n;
      logic clk_en;
      logic ram_ret;
      logic busy;
      logic powered;
      logic err;
   } pwr_out_t;

   localparam pwr_out_t PWR_OUT_RESET = '{
      switch_on: 1'b1, iso: 1'b0, rst_n: 1'b1, clk_en: 1'b1,
      ram_ret: 1'b0, busy: 1'b0, powered: 1'b1, err: 1'b0
   };

   function automatic pwr_out_t pwr_decode(input pwr_state_e st, input logic ret_lat);
      pwr_out_t o;
      o.switch_on = !(st inside {ST_SW_OFF, ST_OFF, ST_ERR});
      o.iso       = st inside {ST_ISO, ST_SW_OFF, ST_OFF, ST_SW_ON, ST_SETTLE, ST_ERR};
      o.rst_n     = st inside {ST_ON, ST_CLK_OFF, ST_RST_REL};
      o.clk_en    = st inside {ST_ON, ST_RST_REL};
      // Retention is only meaningful while the domain is isolated.
      o.ram_ret   = o.iso & ret_lat;
      o.busy      = !(st inside {ST_ON, ST_OFF, ST_ERR});
      o.powered   = (st == ST_ON);
      o.err       = (st == ST_ERR);
      return o;
   endfunction

endpackage

// File: rtl/cgra_pwr_timer.sv
// Clearable saturating up-counter with a >= limit compare, shared by the
// switch-ack timeout and the post-ack settle wait.
module cgra_pwr_timer
   import cgra_power_seq_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             hit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/cgra_power_sequencer.sv
// Power-down / power-up sequencer for the CGRA external domain: orders clock
// gating, isolation, reset and the power switch, with ack timeout and retention.
module cgra_power_sequencer
   import cgra_power_seq_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT   = 1023,
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pwr_down_req_i,
   input  logic       pwr_up_req_i,
   input  logic       retentive_en_i,
   input  logic       clr_err_i,
   input  logic       switch_ack_i,
   output logic       switch_on_o,
   output logic       iso_o,
   output logic       subsys_rst_no,
   output logic       clk_en_o,
   output logic       ram_retentive_o,
   output logic       busy_o,
   output logic       powered_o,
   output logic       done_o,
   output logic       err_o,
   output logic       req_dropped_o,
   output logic [3:0] state_o
);

   // Timer hits on the last cycle of the wait, so the limit is one less than
   // the number of cycles spent in the waiting state.
   localparam logic [CNT_W-1:0] ACK_LIMIT    = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_LIMIT = CNT_W'(SETTLE_CYCLES - 1);

   pwr_state_e       state_q, state_d;
   logic             ret_lat_q, ret_lat_d;
   pwr_out_t         out_q, out_d;
   logic             done_q, done_d;
   logic             drop_q, drop_d;
   logic             tmr_clr, tmr_en, tmr_hit;
   logic [CNT_W-1:0] tmr_limit;

   cgra_pwr_timer u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .limit_i (tmr_limit),
      .hit_o   (tmr_hit)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_ON;
         ret_lat_q <= 1'b0;
         out_q     <= PWR_OUT_RESET;
         done_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_lat_q <= ret_lat_d;
         out_q     <= out_d;
         done_q    <= done_d;
         drop_q    <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ret_lat_d = ret_lat_q;
      unique case (state_q)
         ST_ON: begin
            if (pwr_down_req_i) begin
               state_d   = ST_CLK_OFF;
               ret_lat_d = retentive_en_i;
            end
         end
         ST_CLK_OFF: state_d = ST_ISO;
         ST_ISO:     state_d = ST_SW_OFF;
         ST_SW_OFF: begin
            if (!switch_ack_i) begin
               state_d = ST_OFF;
            end else if (tmr_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_OFF: begin
            if (pwr_up_req_i) begin
               state_d = ST_SW_ON;
            end
         end
         ST_SW_ON: begin
            if (switch_ack_i) begin
               state_d = ST_SETTLE;
            end else if (tmr_hit) begin
               state_d = ST_ERR;
            end
         end
         ST_SETTLE: begin
            if (tmr_hit) begin
               state_d = ST_ISO_REL;
            end
         end
         ST_ISO_REL: state_d = ST_RST_REL;
         ST_RST_REL: state_d = ST_ON;
         ST_ERR: begin
            if (clr_err_i) begin
               state_d = ST_OFF;
            end
         end
         default: state_d = ST_ON;
      endcase
   end

   always_comb begin
      tmr_en    = state_q inside {ST_SW_OFF, ST_SW_ON, ST_SETTLE};
      tmr_clr   = (state_d != state_q) && (state_d inside {ST_SW_OFF, ST_SW_ON, ST_SETTLE});
      tmr_limit = (state_q == ST_SETTLE) ? SETTLE_LIMIT : ACK_LIMIT;
   end

   // Outputs are decoded from the next state so the pins change on the same
   // edge as the state register.
   always_comb begin
      out_d  = pwr_decode(state_d, ret_lat_d);
      done_d = ((state_q == ST_SW_OFF) && (state_d == ST_OFF)) ||
               ((state_q == ST_RST_REL) && (state_d == ST_ON));
      drop_d = (pwr_up_req_i && (state_q != ST_OFF)) ||
               (pwr_down_req_i && (state_q != ST_ON));
   end

   assign switch_on_o     = out_q.switch_on;
   assign iso_o           = out_q.iso;
   assign subsys_rst_no   = out_q.rst_n;
   assign clk_en_o        = out_q.clk_en;
   assign ram_retentive_o = out_q.ram_ret;
   assign busy_o          = out_q.busy;
   assign powered_o       = out_q.powered;
   assign err_o           = out_q.err;
   assign done_o          = done_q;
   assign req_dropped_o   = drop_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_cgra_power_sequencer.sv
// Self-checking bench for cgra_power_sequencer: directed sequences followed by
// random requests, compared each cycle against a phase/cycle-count model.
module tb_cgra_power_sequencer;
   import cgra_power_seq_pkg::*;

   localparam int ACK_TO = 16;
   localparam int SETTLE = 8;

   logic       clk = 1'b0;
   logic       rst, down, up, ret_en, clr, ack;
   logic       switch_on_o, iso_o, subsys_rst_no, clk_en_o, ram_retentive_o;
   logic       busy_o, powered_o, done_o, err_o, req_dropped_o;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   cgra_power_sequencer #(.ACK_TIMEOUT(ACK_TO), .SETTLE_CYCLES(SETTLE)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .pwr_down_req_i  (down),
      .pwr_up_req_i    (up),
      .retentive_en_i  (ret_en),
      .clr_err_i       (clr),
      .switch_ack_i    (ack),
      .switch_on_o     (switch_on_o),
      .iso_o           (iso_o),
      .subsys_rst_no   (subsys_rst_no),
      .clk_en_o        (clk_en_o),
      .ram_retentive_o (ram_retentive_o),
      .busy_o          (busy_o),
      .powered_o       (powered_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .req_dropped_o   (req_dropped_o),
      .state_o         (state_o)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: a coarse phase plus cycle positions inside the phase.
   typedef enum int {P_ON, P_DOWN, P_OFF, P_UP, P_ERR} phase_t;
   phase_t m_phase;
   int     m_t;
   int     m_s;
   bit     m_ret, m_done, m_drop;

   // Switch acknowledge: follows the expected switch state after a delay.
   bit sw_prev;
   int since;
   int ack_delay;
   bit stuck;

   task automatic model_reset();
      m_phase = P_ON;
      m_t = 0;
      m_s = -1;
      m_ret = 1'b0;
      m_done = 1'b0;
      m_drop = 1'b0;
   endtask

   function automatic pwr_state_e exp_state();
      pwr_state_e s;
      case (m_phase)
         P_ON:   s = ST_ON;
         P_OFF:  s = ST_OFF;
         P_ERR:  s = ST_ERR;
         P_DOWN: s = (m_t == 1) ? ST_CLK_OFF : (m_t == 2) ? ST_ISO : ST_SW_OFF;
         default: s = (m_s < 0) ? ST_SW_ON : (m_s < SETTLE) ? ST_SETTLE :
                      (m_s == SETTLE) ? ST_ISO_REL : ST_RST_REL;
      endcase
      return s;
   endfunction

   task automatic model_step(input bit d, input bit u, input bit c, input bit r, input bit a);
      m_drop = (u && m_phase != P_OFF) || (d && m_phase != P_ON);
      m_done = 1'b0;
      case (m_phase)
         P_ON: if (d) begin m_phase = P_DOWN; m_t = 1; m_ret = r; end
         P_DOWN: begin
            if (m_t < 3) m_t++;
            else if (!a) begin m_phase = P_OFF; m_done = 1'b1; end
            else if (m_t - 3 + 1 >= ACK_TO) m_phase = P_ERR;
            else m_t++;
         end
         P_OFF: if (u) begin m_phase = P_UP; m_t = 1; m_s = -1; end
         P_UP: begin
            if (m_s < 0) begin
               if (a) m_s = 0;
               else if (m_t - 1 + 1 >= ACK_TO) m_phase = P_ERR;
               else m_t++;
            end else if (m_s == SETTLE + 1) begin
               m_phase = P_ON; m_done = 1'b1;
            end else m_s++;
         end
         default: if (c) m_phase = P_OFF;
      endcase
   endtask

   task automatic check_all();
      pwr_state_e s;
      bit e_sw, e_iso, e_rstn, e_clk;
      s = exp_state();
      case (s)
         ST_ON:      begin e_sw = 1; e_iso = 0; e_rstn = 1; e_clk = 1; end
         ST_CLK_OFF: begin e_sw = 1; e_iso = 0; e_rstn = 1; e_clk = 0; end
         ST_ISO:     begin e_sw = 1; e_iso = 1; e_rstn = 0; e_clk = 0; end
         ST_SW_OFF:  begin e_sw = 0; e_iso = 1; e_rstn = 0; e_clk = 0; end
         ST_OFF:     begin e_sw = 0; e_iso = 1; e_rstn = 0; e_clk = 0; end
         ST_SW_ON:   begin e_sw = 1; e_iso = 1; e_rstn = 0; e_clk = 0; end
         ST_SETTLE:  begin e_sw = 1; e_iso = 1; e_rstn = 0; e_clk = 0; end
         ST_ISO_REL: begin e_sw = 1; e_iso = 0; e_rstn = 0; e_clk = 0; end
         ST_RST_REL: begin e_sw = 1; e_iso = 0; e_rstn = 1; e_clk = 1; end
         default:    begin e_sw = 0; e_iso = 1; e_rstn = 0; e_clk = 0; end
      endcase
      chk("state", 16'(state_o), 16'(s));
      chk("switch_on", 16'(switch_on_o), 16'(e_sw));
      chk("iso", 16'(iso_o), 16'(e_iso));
      chk("subsys_rst_n", 16'(subsys_rst_no), 16'(e_rstn));
      chk("clk_en", 16'(clk_en_o), 16'(e_clk));
      chk("ram_ret", 16'(ram_retentive_o), 16'(e_iso && m_ret));
      chk("busy", 16'(busy_o), 16'(m_phase == P_DOWN || m_phase == P_UP));
      chk("powered", 16'(powered_o), 16'(m_phase == P_ON));
      chk("err", 16'(err_o), 16'(m_phase == P_ERR));
      chk("done", 16'(done_o), 16'(m_done));
      chk("req_dropped", 16'(req_dropped_o), 16'(m_drop));
   endtask

   task automatic ack_update();
      bit sw;
      sw = !(exp_state() inside {ST_SW_OFF, ST_OFF, ST_ERR});
      if (sw != sw_prev) begin
         sw_prev = sw;
         since = 0;
      end else begin
         since++;
      end
      if (!stuck && since + 1 >= ack_delay) ack = sw;
   endtask

   task automatic cycle();
      bit d, u, c, r, a;
      d = down; u = up; c = clr; r = ret_en; a = ack;
      @(posedge clk);
      model_step(d, u, c, r, a);
      #1;
      check_all();
      down = 1'b0;
      up = 1'b0;
      clr = 1'b0;
      ack_update();
   endtask

   task automatic wait_event(input int maxc, input bit want_err, output int k);
      k = 0;
      for (int i = 1; i <= maxc && k == 0; i++) begin
         cycle();
         if (want_err ? (err_o === 1'b1) : (done_o === 1'b1)) k = i;
      end
   endtask

   initial begin
      int k, drops;
      rst = 1'b1; down = 1'b0; up = 1'b0; ret_en = 1'b0; clr = 1'b0; ack = 1'b1;
      sw_prev = 1'b1; since = 100; ack_delay = 3; stuck = 1'b0;
      model_reset();
      #2;
      check_all();
      chk("rst_counter", dut.u_timer.cnt_q, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) cycle();

      // Retentive power-down, ack drops 3 cycles after switch off.
      ack_delay = 3; ret_en = 1'b1; down = 1'b1;
      wait_event(20, 1'b0, k);
      chk("down_latency", 16'(k), 16'd6);
      ret_en = 1'b0;
      cycle();

      // Power-up, ack rises 2 cycles after switch on, then 8 settle cycles.
      ack_delay = 2; up = 1'b1;
      wait_event(30, 1'b0, k);
      chk("up_latency", 16'(k), 16'd13);
      chk("up_ram_ret", 16'(ram_retentive_o), 16'd0);

      // Ack stuck high during power-down: timeout into ERR, then clear.
      stuck = 1'b1; down = 1'b1;
      wait_event(40, 1'b1, k);
      chk("err_latency", 16'(k), 16'(3 + ACK_TO));
      up = 1'b1;
      cycle();
      clr = 1'b1;
      cycle();
      chk("clr_err_state", 16'(state_o), 16'(ST_OFF));
      stuck = 1'b0; ack_delay = 1;
      repeat (3) cycle();

      // Requests issued mid-sequence are dropped, only the first is honoured.
      ack_delay = 2; drops = 0;
      up = 1'b1; cycle(); drops += int'(req_dropped_o);
      down = 1'b1; cycle(); drops += int'(req_dropped_o);
      up = 1'b1; cycle(); drops += int'(req_dropped_o);
      for (int i = 0; i < 30 && m_phase != P_ON; i++) begin
         cycle();
         drops += int'(req_dropped_o);
      end
      chk("mid_drop_count", 16'(drops), 16'd2);
      chk("mid_final_state", 16'(state_o), 16'(ST_ON));

      // Simultaneous up and down while ON: down wins, up dropped.
      ack_delay = 3; up = 1'b1; down = 1'b1;
      cycle();
      chk("simul_dropped", 16'(req_dropped_o), 16'd1);
      wait_event(30, 1'b0, k);

      // Asynchronous reset in the middle of SETTLE.
      ack_delay = 2; up = 1'b1;
      for (int i = 0; i < 40 && !(m_phase == P_UP && m_s == 3); i++) cycle();
      chk("settle_reached", 16'(state_o), 16'(ST_SETTLE));
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("midrst_counter", dut.u_timer.cnt_q, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // Random requests, clears, retention choice and ack behaviour.
      for (int i = 0; i < 800; i++) begin
         down = ($urandom_range(0, 7) == 0);
         up = ($urandom_range(0, 7) == 0);
         clr = ($urandom_range(0, 5) == 0);
         ret_en = 1'($urandom_range(0, 1));
         ack_delay = $urandom_range(1, 4);
         if ($urandom_range(0, 99) == 0) stuck = !stuck;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cgra_power_sequencer.md
Name: cgra_power_sequencer

Overview:
- Sequences power-down and power-up of the CGRA external subsystem (one power domain).
- Drives the domain's clock enable, isolation, logic reset, power switch and RAM-retention lines in a fixed safe order.
- Handshakes with the power-switch acknowledge and supports an ack timeout and a retentive power-down.
- Sits between the always-on control registers (request and status bits) and the subsystem's power-control pins.

Parameters:
ACK_TIMEOUT, 1023, max cycles waiting for switch ack before error (1..65535)
SETTLE_CYCLES, 8, cycles waited after ack on power-up before isolation release (1..255)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
pwr_down_req_i  in  1  single-cycle power-down request
pwr_up_req_i  in  1  single-cycle power-up request
retentive_en_i  in  1  sampled with pwr_down_req_i; 1 = keep RAM banks retentive while off
clr_err_i  in  1  single-cycle error clear
switch_ack_i  in  1  power-switch acknowledge, follows switch_on_o after a delay
switch_on_o  out  1  1 = domain powered
iso_o  out  1  1 = domain outputs isolated
subsys_rst_no  out  1  domain logic reset, active-low
clk_en_o  out  1  domain clock-gate enable
ram_retentive_o  out  1  RAM banks set retentive
busy_o  out  1  1 in any state other than ON, OFF or ERR
powered_o  out  1  1 only in ON
done_o  out  1  one-cycle pulse on entering ON or OFF from a sequence
err_o  out  1  sticky ack-timeout flag
req_dropped_o  out  1  one-cycle pulse when a request is ignored
state_o  out  4  current state encoding, for status register

Behaviour:
- Reset (async, rst_i=1):
  - state ON.
  - switch_on_o=1, iso_o=0, subsys_rst_no=1, clk_en_o=1.
  - ram_retentive_o=0, err_o=0, all pulses 0, counter 0.
- All outputs are registered and decoded from state only (Moore).
- Power-down path, one state per edge:
  - ON: pwr_down_req_i=1 → CLK_OFF; latch retentive_en_i.
  - CLK_OFF: clk_en_o=0 → ISO.
  - ISO: iso_o=1, subsys_rst_no=0, ram_retentive_o=latched value → SW_OFF.
  - SW_OFF: switch_on_o=0, counter runs. switch_ack_i==0 → OFF with done_o=1. Counter reaching ACK_TIMEOUT with ack still 1 → ERR.
- Power-up path:
  - OFF: pwr_up_req_i=1 → SW_ON.
  - SW_ON: switch_on_o=1, counter runs. switch_ack_i==1 → SETTLE. Timeout → ERR.
  - SETTLE: waits exactly SETTLE_CYCLES cycles → ISO_REL.
  - ISO_REL: iso_o=0, ram_retentive_o=0 → RST_REL.
  - RST_REL: subsys_rst_no=1, clk_en_o=1 → ON with done_o=1.
- Output ordering guarantees:
  - iso_o asserts no later than subsys_rst_no drops.
  - iso_o asserts one cycle before switch_on_o falls.
  - iso_o is released only after ack plus settle.
  - Reset is released one cycle after isolation is released.
- Counter: 16-bit, cleared on entering SW_OFF, SW_ON or SETTLE. Compare is ≥ so no wrap-around is possible.
- ERR state:
  - err_o=1 (sticky), iso_o=1, subsys_rst_no=0, clk_en_o=0.
  - switch_on_o=0; a failed power-up is switched back off.
  - clr_err_i → OFF, err_o=0. Requests in ERR are dropped.
- Request rules:
  - pwr_down_req_i is honoured only in ON; pwr_up_req_i only in OFF.
  - Any other request pulse, including a down request in OFF, an up request in ON, or any request while busy_o=1, is ignored and produces req_dropped_o=1 the next cycle.
  - Requests are never queued.
- Simultaneous up and down requests: in ON the down request wins and the up request counts as dropped; in OFF the converse.
- Ack changes during states that do not wait on it are ignored.
- Reset mid-sequence: the async return to the ON outputs is immediate. This is acceptable because rst_i also resets the domain.
- done_o and req_dropped_o never exceed one cycle. done_o is not produced by clr_err_i.

Decomposition:
- Package cgra_power_seq_pkg:
  - state enum (ON, CLK_OFF, ISO, SW_OFF, OFF, SW_ON, SETTLE, ISO_REL, RST_REL, ERR, 4-bit encoding, values exported on state_o).
  - counter width constant (16).
- Sub-module cgra_pwr_timer: clearable 16-bit up-counter with ≥-limit compare output, used for both the ack timeout and the settle wait.

Test Plan:
- Reset then down request with retentive_en_i=1 and ack dropping 3 cycles after switch off → clk_en_o=0 at +1, iso_o=1/subsys_rst_no=0/ram_retentive_o=1 at +2, switch_on_o=0 at +3, OFF with done_o pulse at +6.
- From OFF, up request with ack rising after 2 cycles and SETTLE_CYCLES=8 → iso_o releases 8 cycles after ack is sampled, subsys_rst_no=1 and clk_en_o=1 one cycle later, ON with done_o, ram_retentive_o=0.
- Down request with switch_ack_i stuck at 1 and ACK_TIMEOUT=16 → ERR after 16 cycles in SW_OFF with err_o=1 and switch_on_o=0; clr_err_i → OFF, err_o=0.
- Up request, down request, then a second up request issued mid-sequence → only the first is honoured; req_dropped_o pulses twice and the final state is ON.
- pwr_up_req_i and pwr_down_req_i in the same cycle while in ON → power-down starts and req_dropped_o=1.
- rst_i asserted during SETTLE → asynchronously ON, switch_on_o=1, iso_o=0, err_o=0, counter 0.
